// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, converter state encoding and BCD correction helper
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg_if.sv
// seg_if: value input and scanned display outputs of the seven-segment driver
interface seg_if;
  logic [7:0] value;
  logic [3:0] digit;
  logic [3:0] anode;
  logic       busy;
  modport master (output value, input digit, anode, busy);
  modport slave  (input value, output digit, anode, busy);
endinterface

// File: rtl/bin8_to_bcd.sv
// bin8_to_bcd: sequential double-dabble converter, display register loads only on COMMIT
module bin8_to_bcd import seg_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  value_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [11:0] bcd_o,
  output logic [7:0]  val_o
);
  conv_state_e state_q, state_d;
  logic [7:0]  cap_q, cap_d;
  logic [11:0] scr_q, scr_d, adj;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d;
  assign adj = {add3(scr_q[11:8]), add3(scr_q[7:4]), add3(scr_q[3:0])};
  // captured value stays intact for last_value; its bits are fed in MSB first by index
  always_comb begin
    state_d = state_q;
    cap_d = cap_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    if (state_q == IDLE && start_i) begin
      cap_d = value_i;
      scr_d = '0;
      cnt_d = '0;
      state_d = SHIFT;
    end
    if (state_q == SHIFT) begin
      scr_d = {adj[10:0], cap_q[3'd7 - cnt_q]};
      cnt_d = cnt_q + 3'd1;
      state_d = cnt_q == 3'd7 ? COMMIT : SHIFT;
    end
    if (state_q == COMMIT) begin
      bcd_d = scr_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cap_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q <= cap_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
    end
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == COMMIT;
  assign bcd_o = bcd_q;
  assign val_o = cap_q;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-bit value to 3-digit multiplexed display with leading-zero blanking
module seg_scan_driver import seg_pkg::*; #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ = 1
) (
  input logic clk,
  input logic rst_n,
  seg_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic BLZ = BLANK_LZ != 0;
  logic          start, busy, done, tick, bl_h, bl_t;
  logic [11:0]   bcd;
  logic [7:0]    val, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    an_q, an_d, dg_q, dg_d;
  assign start = bus.value != last_q;
  bin8_to_bcd u_conv (
    .clk(clk), .rst_n(rst_n), .start_i(start), .value_i(bus.value),
    .busy_o(busy), .done_o(done), .bcd_o(bcd), .val_o(val)
  );
  // outputs are built from registered display and index, so they never mix old and new
  always_comb begin
    tick = cnt_q == LAST;
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = tick ? idx_q + IW'(1) : idx_q;
    last_d = done ? val : last_q;
    bl_h = BLZ && bcd[11:8] == 4'd0;
    bl_t = bl_h && bcd[7:4] == 4'd0;
    an_d = idx_q == IW'(0) ? 4'b1110 :
           idx_q == IW'(1) ? (bl_t ? ANODE_OFF : 4'b1101) :
           idx_q == IW'(2) ? (bl_h ? ANODE_OFF : 4'b1011) : ANODE_OFF;
    dg_d = an_d == ANODE_OFF ? 4'd0 :
           idx_q == IW'(0) ? bcd[3:0] :
           idx_q == IW'(1) ? bcd[7:4] : bcd[11:8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      an_q <= ANODE_OFF;
      dg_q <= '0;
    end else begin
      last_q <= last_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q <= an_d;
      dg_q <= dg_d;
    end
  assign bus.anode = an_q;
  assign bus.digit = dg_q;
  assign bus.busy = busy;
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the number of clk cycles each digit position is shown.
REQ-002 Parameter BLANK_LZ, default 1, SHALL enable leading-zero blanking when 1.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port value, input, 8, SHALL be the unsigned binary number to display (0..255).
REQ-006 Port digit, output, 4, SHALL be the BCD digit for the currently enabled position; it feeds the downstream BCD-to-cathode decoder.
REQ-007 Port anode, output, 4, SHALL be the active-low digit enables; anode[0] is the rightmost digit.
REQ-008 Port busy, output, 1, SHALL be high while a binary-to-BCD conversion is in progress.

Function
REQ-009 The converter FSM SHALL have the states IDLE, SHIFT and COMMIT.
REQ-010 In IDLE, when value differs from last_value, the block SHALL capture value, clear a 12-bit BCD scratch register, clear the shift count and enter SHIFT on the next edge.
REQ-011 In SHIFT, each cycle SHALL add 3 to every scratch nibble >= 5 and then shift {scratch, captured} left by one; after exactly 8 shifts the FSM SHALL enter COMMIT.
REQ-012 In COMMIT, the block SHALL copy the scratch into the hundreds, tens and ones display registers in a single cycle, set last_value to the captured value and return to IDLE.
REQ-013 Latency SHALL be exactly 10 cycles from the first edge that samples a changed value to the edge that updates the display registers.
REQ-014 busy SHALL be high in SHIFT and COMMIT and low in IDLE.
REQ-015 Changes on value during SHIFT or COMMIT SHALL be ignored until IDLE.
- If value differs from last_value in IDLE, a new conversion SHALL start.
- The final value SHALL therefore always be displayed; intermediate values may be skipped.
REQ-016 The display registers SHALL never show a partially converted result.
REQ-017 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0.
- Its terminal cycle SHALL be the scan tick.
REQ-018 The 2-bit scan index SHALL increment on each scan tick and wrap from 3 to 0.
REQ-019 The position mapping SHALL be:
- index 0 -> ones, anode 4'b1110
- index 1 -> tens, anode 4'b1101
- index 2 -> hundreds, anode 4'b1011
- index 3 -> always blank, anode 4'b1111, digit 0
REQ-020 With BLANK_LZ=1:
- hundreds SHALL be blanked (anode 4'b1111) when it is 0.
- tens SHALL be blanked when hundreds and tens are both 0.
- ones SHALL never be blanked.
REQ-021 digit and anode SHALL be registered and SHALL reflect the scan index and display registers with one cycle of latency.
REQ-022 A display-register update that coincides with a scan tick SHALL be visible at the next output update; no glitch combination SHALL occur.

Reset
REQ-023 While rst_n is low, the block SHALL immediately hold:
- anode 4'b1111, digit 4'd0, busy 0
- FSM IDLE, last_value 0, display registers 0, refresh counter 0, scan index 0
REQ-024 A reset asserted mid-conversion SHALL abort the conversion; the display SHALL read 0 after release.
REQ-025 After reset release, a non-zero value SHALL start a conversion on the first clk edge.

Structure
REQ-026 The shared package seg_pkg SHALL hold:
- NUM_DIGITS=4
- ANODE_OFF=4'b1111
- the FSM state enumeration
REQ-027 The converter (REQ-009..016) SHALL be a sub-module named bin8_to_bcd, with a start/value input and busy/bcd[11:0]/done outputs.
REQ-028 seg_scan_driver SHALL instantiate bin8_to_bcd once and contain the refresh, scan and blanking logic.

Verification (bench REFRESH_DIV=4)
REQ-029 Scenario: value=255 after reset -> busy high for 9 cycles; display 2,5,5; anode cycles 1110,1101,1011,1111 every 4 cycles with digit 5,5,2,0.
REQ-030 Scenario: value=7 with BLANK_LZ=1 -> only anode 4'b1110 ever asserts, with digit 7; with BLANK_LZ=0, tens and hundreds show digit 0.
REQ-031 Scenario: value 100->101->102 on consecutive cycles mid-conversion -> display 1,0,0 first, then 1,0,2; 1,0,1 never appears.
REQ-032 Scenario: rst_n low during SHIFT (value=200) -> outputs go to reset values immediately, without waiting for clk; after release the display converges to 2,0,0.
REQ-033 Scenario: value=99 -> display 0,9,9, hundreds blanked; then value=100 -> tens 0 now displayed, not blanked.
REQ-034 Scenario: scan wrap -> index 3->0 transition produces anode 4'b1111 then 4'b1110, with no cycle where two anodes are low.
